// File: rtl/des_pkg.sv
// DES tables, widths, FSM states and the PC-1/PC-2/rotation helpers.
// Latency: none; the helpers are purely combinational.
// Backpressure: not applicable.
package des_pkg;

  localparam int BLOCK_W  = 64;
  localparam int HALF_W   = 32;
  localparam int KEY_W    = 64;
  localparam int CD_W     = 28;
  localparam int SUBKEY_W = 48;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  // Every table entry is a 1-based FIPS bit number; vector index = bit number - 1.
  localparam int E_TAB [SUBKEY_W] = '{
    32, 1, 2, 3, 4, 5,    4, 5, 6, 7, 8, 9,    8, 9,10,11,12,13,   12,13,14,15,16,17,
    16,17,18,19,20,21,   20,21,22,23,24,25,   24,25,26,27,28,29,   28,29,30,31,32, 1};

  localparam int P_TAB [HALF_W] = '{
    16, 7,20,21, 29,12,28,17,  1,15,23,26,  5,18,31,10,
     2, 8,24,14, 32,27, 3, 9, 19,13,30, 6, 22,11, 4,25};

  localparam int PC1_TAB [2*CD_W] = '{
    57,49,41,33,25,17, 9,  1,58,50,42,34,26,18, 10, 2,59,51,43,35,27, 19,11, 3,60,52,44,36,
    63,55,47,39,31,23,15,  7,62,54,46,38,30,22, 14, 6,61,53,45,37,29, 21,13, 5,28,20,12, 4};

  localparam int PC2_TAB [SUBKEY_W] = '{
    14,17,11,24, 1, 5,  3,28,15, 6,21,10, 23,19,12, 4,26, 8, 16, 7,27,20,13, 2,
    41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};

  // SBOX[box][row*16 + col]
  localparam int SBOX [8][64] = '{
    '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,  0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
       4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0, 15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
    '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,  3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
       0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15, 13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
    '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
      13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,  1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
    '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15, 13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
      10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,  3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
    '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9, 14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
       4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14, 11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
    '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11, 10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
       9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,  4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
    '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1, 13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
       1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,  6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
    '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,  1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
       7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,  2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

  // Per-round rotation of C and D; decrypt round 1 uses the unrotated C0/D0.
  localparam logic [1:0] SHIFT_ENC [16] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
                                            2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
  localparam logic [1:0] SHIFT_DEC [16] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
                                            2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

  // Result index 0..27 is C, 28..55 is D.
  function automatic logic [2*CD_W-1:0] pc1(input logic [KEY_W-1:0] key);
    logic [2*CD_W-1:0] cd;
    cd = '0;
    for (int j = 0; j < 2*CD_W; j++) cd[j] = key[PC1_TAB[j]-1];
    return cd;
  endfunction

  function automatic logic [SUBKEY_W-1:0] pc2(input logic [2*CD_W-1:0] cd);
    logic [SUBKEY_W-1:0] k;
    k = '0;
    for (int j = 0; j < SUBKEY_W; j++) k[j] = cd[PC2_TAB[j]-1];
    return k;
  endfunction

  // Index 0 is the leftmost FIPS bit, so a FIPS left rotate is a numeric right rotate.
  function automatic logic [CD_W-1:0] rot_cd(input logic [CD_W-1:0] x, input logic [1:0] s,
                                             input logic right);
    logic [CD_W-1:0] y;
    if (right) y = (x << s) | (x >> (CD_W - int'(s)));
    else       y = (x >> s) | (x << (CD_W - int'(s)));
    return y;
  endfunction

endpackage

// File: rtl/des_round_engine_f.sv
// DES round function f(R,K) = P(S(E(R) xor K)).
// Latency: combinational, single cycle.
// Backpressure: not applicable.
module des_f_function
  import des_pkg::*;
(
  input  logic [HALF_W-1:0]   r,
  input  logic [SUBKEY_W-1:0] k,
  output logic [HALF_W-1:0]   f
);

  logic [SUBKEY_W-1:0] x;
  logic [HALF_W-1:0]   s_out;
  logic [1:0]          row;
  logic [3:0]          col;
  logic [3:0]          sv;

  // Expand, mix with the subkey, substitute through the eight S-boxes, permute.
  always_comb begin
    x     = '0;
    s_out = '0;
    f     = '0;
    row   = '0;
    col   = '0;
    sv    = '0;
    for (int j = 0; j < SUBKEY_W; j++) x[j] = r[E_TAB[j]-1] ^ k[j];
    for (int m = 0; m < 8; m++) begin
      row = {x[6*m], x[6*m+5]};
      col = {x[6*m+1], x[6*m+2], x[6*m+3], x[6*m+4]};
      sv  = 4'(SBOX[m][{row, col}]);
      s_out[4*m]   = sv[3];
      s_out[4*m+1] = sv[2];
      s_out[4*m+2] = sv[1];
      s_out[4*m+3] = sv[0];
    end
    for (int j = 0; j < HALF_W; j++) f[j] = s_out[P_TAB[j]-1];
  end

endmodule

// File: rtl/des_round_engine.sv
// Iterative 16-round DES Feistel core with on-the-fly key schedule.
// Latency: out_valid rises 16 edges after the accepting edge; 18 cycles/block minimum.
// Backpressure: in_ready low while busy; result held in DONE until out_ready.
module des_round_engine
  import des_pkg::*;
#(
  parameter int ROUNDS = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_block,
  input  logic [KEY_W-1:0]   in_key,
  input  logic               in_decrypt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_block,
  output logic               busy
);

  state_t              state_q, state_d;
  logic [HALF_W-1:0]   l_q, r_q, f_out;
  logic [CD_W-1:0]     c_q, d_q, c_rot, d_rot;
  logic [2*CD_W-1:0]   cd_in;
  logic [SUBKEY_W-1:0] k_n;
  logic [1:0]          shamt;
  logic [4:0]          rnd_q;
  logic                mode_q;
  logic                accept;
  logic                key_parity_unused;

  // Parity bits 8,16,...,64 never reach PC-1.
  assign key_parity_unused = ^{in_key[7], in_key[15], in_key[23], in_key[31],
                               in_key[39], in_key[47], in_key[55], in_key[63]};

  assign cd_in     = pc1(in_key);
  assign accept    = in_valid && in_ready;
  assign out_block = {l_q, r_q};

  // Rotate the registered C/D for the current round and derive its subkey.
  always_comb begin
    shamt = mode_q ? SHIFT_DEC[rnd_q[3:0]] : SHIFT_ENC[rnd_q[3:0]];
    c_rot = rot_cd(c_q, shamt, mode_q);
    d_rot = rot_cd(d_q, shamt, mode_q);
    k_n   = pc2({d_rot, c_rot});
  end

  des_f_function u_f (
    .r (r_q),
    .k (k_n),
    .f (f_out)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ROUND;
      end
      ROUND: begin
        if (rnd_q == 5'(ROUNDS-1)) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: load on accept, one Feistel round per cycle in ROUND, hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      l_q    <= '0;
      r_q    <= '0;
      c_q    <= '0;
      d_q    <= '0;
      rnd_q  <= '0;
      mode_q <= 1'b0;
    end else if (accept) begin
      l_q    <= in_block[HALF_W-1:0];
      r_q    <= in_block[BLOCK_W-1:HALF_W];
      c_q    <= cd_in[CD_W-1:0];
      d_q    <= cd_in[2*CD_W-1:CD_W];
      rnd_q  <= '0;
      mode_q <= in_decrypt;
    end else if (state_q == ROUND) begin
      l_q   <= r_q;
      r_q   <= l_q ^ f_out;
      c_q   <= c_rot;
      d_q   <= d_rot;
      rnd_q <= rnd_q + 5'd1;
    end
  end

  rounds_legal: assert property (@(posedge clk) disable iff (rst) ROUNDS == 16);

endmodule

// File: tb/tb_des_round_engine.sv
// Directed bench for des_round_engine: known-answer vectors plus handshake corner cases.
// Latency: checks 16 edges from accept to out_valid.
// Backpressure: exercises out_ready low in DONE and in_valid while busy.
module tb_des_round_engine;

  logic        clk, rst, in_valid, in_ready, in_decrypt, out_valid, out_ready, busy;
  logic [63:0] in_block, in_key, out_block;

  int n_assert = 0;
  int n_fail   = 0;

  des_round_engine #(.ROUNDS(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block),
    .in_key(in_key), .in_decrypt(in_decrypt), .out_valid(out_valid), .out_ready(out_ready),
    .out_block(out_block), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200us");
    $fatal(1);
  end

  typedef struct {
    string       name;
    logic [63:0] blk;
    logic [63:0] key;
    logic        dec;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs [6];

  // FIPS hex (bit 1 leftmost) to port vector (index 0 = bit 1).
  function automatic logic [63:0] fips64(input logic [63:0] h);
    logic [63:0] v;
    for (int i = 0; i < 64; i++) v[i] = h[63-i];
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %b required %b", name, act, exp);
    end
  endtask

  // Present a block and return #1 after the edge that accepted it.
  task automatic send(input logic [63:0] blk, input logic [63:0] key, input logic dec);
    int w;
    in_block   = blk;
    in_key     = key;
    in_decrypt = dec;
    in_valid   = 1'b1;
    w = 0;
    while (!in_ready && w < 100) begin
      @(posedge clk); #1; w++;
    end
    chk1("accept_wait", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int edges);
    edges = 0;
    while (!out_valid && edges < 200) begin
      @(posedge clk); #1; edges++;
    end
  endtask

  task automatic expect_out(input string name, input logic [63:0] exp);
    int e;
    wait_out(e);
    chk({name, "_latency"}, 64'(e), 64'd16);
    chk({name, "_block"}, out_block, exp);
  endtask

  logic [63:0] ref1, held;
  int          e;

  initial begin
    ref1       = fips64(64'h0A4CD99543423234);
    // IP(0123456789ABCDEF) = CC00CCFFF0AAF0AA; IP(85E813540F0AB405) = 0A4CD99543423234.
    // 0E329232EA6D0D73 encrypts 8787878787878787 to 0; IP(8787...) = 0000FFFFFF0000FF.
    vecs[0] = '{"fips_enc",   fips64(64'hCC00CCFFF0AAF0AA), fips64(64'h133457799BBCDFF1), 1'b0, ref1};
    vecs[1] = '{"fips_dec",   fips64(64'h0A4CD99543423234), fips64(64'h133457799BBCDFF1), 1'b1,
                fips64(64'hCC00CCFFF0AAF0AA)};
    vecs[2] = '{"parity_enc", fips64(64'hCC00CCFFF0AAF0AA), fips64(64'h123556789ABDDEF0), 1'b0, ref1};
    vecs[3] = '{"parity_dec", fips64(64'h0A4CD99543423234), fips64(64'h123556789ABDDEF0), 1'b1,
                fips64(64'hCC00CCFFF0AAF0AA)};
    vecs[4] = '{"k0e32_enc",  fips64(64'h0000FFFFFF0000FF), fips64(64'h0E329232EA6D0D73), 1'b0, 64'h0};
    vecs[5] = '{"k0e32_dec",  64'h0, fips64(64'h0E329232EA6D0D73), 1'b1,
                fips64(64'h0000FFFFFF0000FF)};

    rst = 1'b1; in_valid = 1'b0; in_block = '0; in_key = '0; in_decrypt = 1'b0; out_ready = 1'b1;
    #2;
    chk1("reset_in_ready", in_ready, 1'b1);
    chk1("reset_out_valid", out_valid, 1'b0);
    chk1("reset_busy", busy, 1'b0);
    chk("reset_out_block", out_block, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Known-answer table.
    for (int i = 0; i < 6; i++) begin
      send(vecs[i].blk, vecs[i].key, vecs[i].dec);
      expect_out(vecs[i].name, vecs[i].exp);
      @(posedge clk); #1;
      chk1({vecs[i].name, "_idle"}, in_ready, 1'b1);
    end

    // Backpressure: result must hold for 10 cycles with out_ready low.
    out_ready = 1'b0;
    send(vecs[0].blk, vecs[0].key, 1'b0);
    expect_out("bp", ref1);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("bp_hold_block", out_block, ref1);
      chk1("bp_hold_valid", out_valid, 1'b1);
      chk1("bp_hold_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk1("bp_release_valid", out_valid, 1'b0);
    chk1("bp_release_in_ready", in_ready, 1'b1);

    // in_valid with a different block during round 7 must not disturb the block in flight.
    send(vecs[0].blk, vecs[0].key, 1'b0);
    repeat (6) begin @(posedge clk); #1; end
    in_block = vecs[4].blk; in_key = vecs[4].key; in_decrypt = 1'b1; in_valid = 1'b1;
    chk1("busy_in_ready", in_ready, 1'b0);
    in_decrypt = 1'b0;
    wait_out(e);
    chk("busy_latency", 64'(e + 6), 64'd16);
    chk("busy_block", out_block, ref1);
    chk1("busy_done_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    chk1("busy_back_idle", busy, 1'b0);
    chk1("busy_idle_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    chk1("busy_second_accepted", busy, 1'b1);
    in_valid = 1'b0;
    expect_out("busy_second", vecs[4].exp);
    @(posedge clk); #1;

    // Asynchronous reset during round 9 aborts the block.
    send(vecs[0].blk, vecs[0].key, 1'b0);
    repeat (8) begin @(posedge clk); #1; end
    chk1("mid_busy_before", busy, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk1("mid_rst_out_valid", out_valid, 1'b0);
    chk1("mid_rst_in_ready", in_ready, 1'b1);
    chk1("mid_rst_busy", busy, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk1("mid_release_in_ready", in_ready, 1'b1);
    send(vecs[0].blk, vecs[0].key, 1'b0);
    expect_out("mid_after", ref1);
    @(posedge clk); #1;

    held = out_block;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
